// File: rtl/uart_fifo_core.sv
// Full-duplex UART: FIFO-buffered transmitter plus receiver with frame/parity error flags.
// Define UART_PARITY_EN to add one parity bit per frame (even/odd chosen by PARITY_ODD).
module uart_fifo_core #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_level,
    output logic                            tx_busy,
    output logic                            uart_tx,
    input  logic                            uart_rx,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    output logic                            rx_frame_err,
    output logic                            rx_parity_err
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int RCW = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  TX_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  TX_STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [RCW-1:0] RX_HALF_END = RCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RCW-1:0] RX_FULL_END = RCW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  LAST_BIT    = IW'(DATA_BITS - 1);
    localparam logic [LW-1:0]  FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam bit PARAMS_OK = (CLKS_PER_BIT >= 4) && (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                               (STOP_BITS == 1 || STOP_BITS == 2) && (FIFO_DEPTH >= 2) &&
                               ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                               (PARITY_ODD == 0 || PARITY_ODD == 1);
`ifdef UART_PARITY_EN
    localparam logic PARITY_IS_ODD = (PARITY_ODD != 0);
`endif

    if (!PARAMS_OK) begin : g_bad_params
        $error("uart_fifo_core: illegal parameter combination");
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
    logic [PW-1:0]        wrPtr, rdPtr;
    logic [LW-1:0]        count;
    logic                 push, pop, fifoEmpty;
    logic [DATA_BITS-1:0] headWord;

    assign tx_ready  = rst_n && (count != FULL_LEVEL);
    assign push      = tx_valid && tx_ready;
    assign fifoEmpty = (count == '0);
    assign headWord  = fifoMem[rdPtr];
    assign tx_level  = count;

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            if (push && !pop)      count <= count + LW'(1);
            else if (pop && !push) count <= count - LW'(1);
        end
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } txState_t;

    txState_t             txState, txNext;
    logic [CW-1:0]        txCnt;
    logic [IW-1:0]        txIdx;
    logic [DATA_BITS-1:0] txShift;
    logic                 txBitEnd;
`ifdef UART_PARITY_EN
    logic                 txParity;
`endif

    // The stop phase spans STOP_BITS bit periods; every other phase spans one.
    assign txBitEnd = (txState == TX_STOP) ? (txCnt == TX_STOP_END) : (txCnt == TX_BIT_END);

    always_ff @(posedge clk) begin
        if (!rst_n) txState <= TX_IDLE;
        else        txState <= txNext;
    end

    always_comb begin
        txNext = txState;
        case (txState)
            TX_IDLE:   if (!fifoEmpty) txNext = TX_START;
            TX_START:  if (txBitEnd) txNext = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (txBitEnd && txIdx == LAST_BIT) txNext = TX_PARITY;
            TX_PARITY: if (txBitEnd) txNext = TX_STOP;
`else
            TX_DATA:   if (txBitEnd && txIdx == LAST_BIT) txNext = TX_STOP;
`endif
            TX_STOP:   if (txBitEnd) txNext = fifoEmpty ? TX_IDLE : TX_START;
            default:   txNext = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        tx_busy = (txState != TX_IDLE);
        pop     = !fifoEmpty && ((txState == TX_IDLE) || (txState == TX_STOP && txBitEnd));
        case (txState)
            TX_START:  uart_tx = 1'b0;
            TX_DATA:   uart_tx = txShift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: uart_tx = txParity;
`endif
            default:   uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txCnt   <= '0;
            txIdx   <= '0;
            txShift <= '0;
`ifdef UART_PARITY_EN
            txParity <= 1'b0;
`endif
        end else begin
            txCnt <= (txState == TX_IDLE || txBitEnd) ? '0 : txCnt + CW'(1);
            if (pop) begin
                txShift <= headWord;
`ifdef UART_PARITY_EN
                txParity <= (^headWord) ^ PARITY_IS_ODD;
`endif
            end else if (txState == TX_DATA && txBitEnd) begin
                txShift <= txShift >> 1;
                txIdx   <= (txIdx == LAST_BIT) ? '0 : txIdx + IW'(1);
            end
        end
    end

    // ---------------- RX ----------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rxState_t;

    rxState_t             rxState, rxNext;
    logic                 rxSync1, rxSync2;
    logic [RCW-1:0]       rxCnt;
    logic [IW-1:0]        rxIdx;
    logic [DATA_BITS-1:0] rxShift;
    logic                 rxTick, rxDone;
`ifdef UART_PARITY_EN
    logic                 rxParErr;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
        end else begin
            rxSync1 <= uart_rx;
            rxSync2 <= rxSync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rxState <= RX_IDLE;
        else        rxState <= rxNext;
    end

    always_comb begin
        rxNext = rxState;
        case (rxState)
            RX_IDLE:   if (!rxSync2) rxNext = RX_START;
            RX_START:  if (rxTick) rxNext = rxSync2 ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:   if (rxTick && rxIdx == LAST_BIT) rxNext = RX_PARITY;
            RX_PARITY: if (rxTick) rxNext = RX_STOP;
`else
            RX_DATA:   if (rxTick && rxIdx == LAST_BIT) rxNext = RX_STOP;
`endif
            // A low stop sample may be a line break; wait for the line to recover.
            RX_STOP:   if (rxTick) rxNext = rxSync2 ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rxSync2) rxNext = RX_IDLE;
            default:   rxNext = RX_IDLE;
        endcase
    end

    always_comb begin
        rxTick = 1'b0;
        if (rxState == RX_START)
            rxTick = (rxCnt == RX_HALF_END);
        else if (rxState != RX_IDLE && rxState != RX_BREAK)
            rxTick = (rxCnt == RX_FULL_END);
        rxDone = (rxState == RX_STOP) && rxTick;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxCnt        <= '0;
            rxIdx        <= '0;
            rxShift      <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rxParErr      <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rxCnt    <= (rxState == RX_IDLE || rxState == RX_BREAK || rxTick) ? '0 : rxCnt + RCW'(1);
            rx_valid <= rxDone;
            if (rxState == RX_DATA && rxTick) begin
                rxShift <= {rxSync2, rxShift[DATA_BITS-1:1]};
                rxIdx   <= (rxIdx == LAST_BIT) ? '0 : rxIdx + IW'(1);
            end
`ifdef UART_PARITY_EN
            if (rxState == RX_PARITY && rxTick)
                rxParErr <= rxSync2 ^ (^rxShift) ^ PARITY_IS_ODD;
`endif
            if (rxDone) begin
                rx_data      <= rxShift;
                rx_frame_err <= !rxSync2;
`ifdef UART_PARITY_EN
                rx_parity_err <= rxParErr;
`endif
            end
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
// Covers the parity path when UART_PARITY_EN is defined (even parity).
module tb_uart_fifo_core;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS  = 11;
    localparam int RX_LAT = 47;
`else
    localparam int NBITS  = 10;
    localparam int RX_LAT = 43;
`endif

    logic       clk = 1'b0;
    logic       rst_n, tx_valid, tx_ready, tx_busy, uart_tx, uart_rx;
    logic       rx_valid, rx_frame_err, rx_parity_err;
    logic [7:0] tx_data, rx_data;
    logic [2:0] tx_level;
    logic       loopEn, rxDrive;

    int         vectors = 0;
    int         miscompares = 0;
    int         rxPulses = 0;
    logic [7:0] lastData = '0;
    logic       lastFe = 1'b0, lastPe = 1'b0;

    always #5 clk = ~clk;

    assign uart_rx = loopEn ? uart_tx : rxDrive;

    uart_fifo_core #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_level(tx_level), .tx_busy(tx_busy), .uart_tx(uart_tx),
        .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rxPulses = rxPulses + 1;
            lastData = rx_data;
            lastFe   = rx_frame_err;
            lastPe   = rx_parity_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line bits in transmission order: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic expect_frame(input logic [7:0] d, input string tag);
        logic [10:0] fb;
        fb = frame_bits(d);
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, i, c), uart_tx, fb[i]);
                @(negedge clk);
            end
        end
    endtask

    task automatic drive_bits(input logic [10:0] fb);
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                rxDrive = fb[i];
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int          base;
        int          firstAt;
        int          lowCount;
        logic [10:0] fb;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; loopEn = 1'b0; rxDrive = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        chk("rst_parity_err", rx_parity_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);

        // Single byte 0xA5: queued one cycle, popped, then a full frame.
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t1_level_queued", tx_level, 1);
        chk("t1_busy_before", tx_busy, 0);
        chk("t1_line_idle", uart_tx, 1);
        @(negedge clk);
        chk("t1_level_popped", tx_level, 0);
        chk("t1_busy_on", tx_busy, 1);
        expect_frame(8'hA5, "t1");
        chk("t1_busy_off", tx_busy, 0);
        chk("t1_line_after", uart_tx, 1);

        // Six pushes on consecutive cycles; the first is popped at once, so the sixth meets a full FIFO.
        fork
            begin
                tx_data = 8'h01; tx_valid = 1'b1;
                @(negedge clk); tx_data = 8'h02;
                @(negedge clk); tx_data = 8'h03;
                @(negedge clk); tx_data = 8'h04;
                @(negedge clk); tx_data = 8'h05;
                @(negedge clk);
                chk("t2_level_full", tx_level, 4);
                chk("t2_ready_full", tx_ready, 0);
                tx_data = 8'h06;
                @(negedge clk);
                chk("t2_level_refused", tx_level, 4);
                tx_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                for (int d = 1; d <= 5; d++) expect_frame(8'(d), $sformatf("t2_f%0d", d));
            end
        join
        chk("t2_busy_off", tx_busy, 0);
        chk("t2_level_empty", tx_level, 0);
        chk("t2_line_idle", uart_tx, 1);

        // Loopback 0x3C, with exact push-to-rx_valid latency.
        loopEn = 1'b1;
        base = rxPulses;
        firstAt = -1;
        tx_data = 8'h3C; tx_valid = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) tx_valid = 1'b0;
            if (rx_valid && firstAt < 0) firstAt = k;
        end
        chk("t3_latency", firstAt, RX_LAT);
        chk("t3_pulses", rxPulses - base, 1);
        chk("t3_data", lastData, 8'h3C);
        chk("t3_frame_err", lastFe, 0);
        chk("t3_parity_err", lastPe, 0);
        loopEn = 1'b0;
        rxDrive = 1'b1;
        repeat (4) @(negedge clk);

        // Glitch, then a frame with a low stop bit followed by a held break, then recovery.
        base = rxPulses;
        rxDrive = 1'b0;
        @(negedge clk);
        rxDrive = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_glitch_pulses", rxPulses - base, 0);
        fb = frame_bits(8'h81);
        fb[NBITS-1] = 1'b0;
        drive_bits(fb);
        repeat (40) @(negedge clk);
        chk("t4_break_pulses", rxPulses - base, 1);
        chk("t4_break_data", lastData, 8'h81);
        chk("t4_break_frame_err", lastFe, 1);
        rxDrive = 1'b1;
        repeat (8) @(negedge clk);
        drive_bits(frame_bits(8'h55));
        rxDrive = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_recover_pulses", rxPulses - base, 2);
        chk("t4_recover_data", lastData, 8'h55);
        chk("t4_recover_frame_err", lastFe, 0);

        // Reset during data bit 3 with three bytes still queued.
        tx_data = 8'h11; tx_valid = 1'b1;
        @(negedge clk); tx_data = 8'h22;
        @(negedge clk); tx_data = 8'h33;
        @(negedge clk); tx_data = 8'h44;
        @(negedge clk); tx_valid = 1'b0;
        chk("t5_level_queued", tx_level, 3);
        repeat (15) @(negedge clk);
        chk("t5_bit3_low", uart_tx, 0);
        chk("t5_busy_mid", tx_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_line", uart_tx, 1);
        chk("t5_rst_level", tx_level, 0);
        chk("t5_rst_busy", tx_busy, 0);
        chk("t5_rst_ready", tx_ready, 0);
        rst_n = 1'b1;
        lowCount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lowCount++;
        end
        chk("t5_no_frames", lowCount, 0);
        chk("t5_level_after", tx_level, 0);

`ifdef UART_PARITY_EN
        // Loopback 0x07 carries parity bit 1; then a frame with the parity bit flipped.
        loopEn = 1'b1;
        base = rxPulses;
        tx_data = 8'h07; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        expect_frame(8'h07, "t6");
        repeat (8) @(negedge clk);
        chk("t6_pulses", rxPulses - base, 1);
        chk("t6_data", lastData, 8'h07);
        chk("t6_parity_ok", lastPe, 0);
        loopEn = 1'b0;
        rxDrive = 1'b1;
        repeat (4) @(negedge clk);
        fb = frame_bits(8'h07);
        fb[NBITS-2] = ~fb[NBITS-2];
        drive_bits(fb);
        rxDrive = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_bad_pulses", rxPulses - base, 2);
        chk("t6_bad_data", lastData, 8'h07);
        chk("t6_bad_parity", lastPe, 1);
        chk("t6_bad_frame_err", lastFe, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
